// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response handshakes and data-memory port signals for mem_access_ctrl.
// slave is the controller side; master is the pipeline/memory side.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;

    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_adrs;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_r_en1;
    logic [ADDR_W-1:0] mem_r_adrs1;
    logic [DATA_W-1:0] mem_data_out1;

    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out1,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr,
        output mem_w_en, mem_w_adrs, mem_data_in, mem_r_en1, mem_r_adrs1, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out1,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr,
        input  mem_w_en, mem_w_adrs, mem_data_in, mem_r_en1, mem_r_adrs1, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// In-order load/store request controller: a small FIFO feeds the memory write port and
// read port 1, and load data is returned over a valid/ready response handshake.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    mem_access_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [LAT_W-1:0]   r_lat, w_lat_nxt;

    logic               r_fifo_we   [DEPTH];
    logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [DEPTH];

    logic               r_w_en, w_w_en_nxt;
    logic [ADDR_W-1:0]  r_w_adrs, w_w_adrs_nxt;
    logic [DATA_W-1:0]  r_data_in, w_data_in_nxt;
    logic               r_r_en1, w_r_en1_nxt;
    logic [ADDR_W-1:0]  r_r_adrs1, w_r_adrs1_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
    logic [ADDR_W-1:0]  r_rsp_addr, w_rsp_addr_nxt;

    logic w_full, w_empty, w_push, w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // Acceptance depends only on the registered count, so a same-edge pop never frees a slot.
    assign w_push  = bus.req_valid && !w_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_nxt       = r_lat;
        w_pop           = 1'b0;
        w_w_en_nxt      = 1'b0;
        w_w_adrs_nxt    = r_w_adrs;
        w_data_in_nxt   = r_data_in;
        w_r_en1_nxt     = 1'b0;
        w_r_adrs1_nxt   = r_r_adrs1;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_addr_nxt  = r_rsp_addr;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (r_fifo_we[r_rptr]) begin
                        w_w_en_nxt    = 1'b1;
                        w_w_adrs_nxt  = r_fifo_addr[r_rptr];
                        w_data_in_nxt = r_fifo_data[r_rptr];
                    end else begin
                        w_r_en1_nxt   = 1'b1;
                        w_r_adrs1_nxt = r_fifo_addr[r_rptr];
                        w_lat_nxt     = LAT_W'(RD_LAT);
                        w_state_nxt   = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (r_lat == '0) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = bus.mem_data_out1;
                    w_rsp_addr_nxt  = r_r_adrs1;
                    w_state_nxt     = StResp;
                end else begin
                    w_lat_nxt = r_lat - LAT_W'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_lat       <= '0;
            r_w_en      <= 1'b0;
            r_w_adrs    <= '0;
            r_data_in   <= '0;
            r_r_en1     <= 1'b0;
            r_r_adrs1   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_lat       <= w_lat_nxt;
            r_w_en      <= w_w_en_nxt;
            r_w_adrs    <= w_w_adrs_nxt;
            r_data_in   <= w_data_in_nxt;
            r_r_en1     <= w_r_en1_nxt;
            r_r_adrs1   <= w_r_adrs1_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wptr]   <= bus.req_we;
            r_fifo_addr[r_wptr] <= bus.req_addr;
            r_fifo_data[r_wptr] <= bus.req_wdata;
        end
    end

    assign bus.req_ready   = !w_full;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_addr    = r_rsp_addr;
    assign bus.mem_w_en    = r_w_en;
    assign bus.mem_w_adrs  = r_w_adrs;
    assign bus.mem_data_in = r_data_in;
    assign bus.mem_r_en1   = r_r_en1;
    assign bus.mem_r_adrs1 = r_r_adrs1;
    assign bus.busy        = !w_empty || (r_state != StIdle);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random requests against a request-order
// scoreboard plus a shadow memory; the memory itself is a one-cycle-latency model.
module tb_mem_access_ctrl;
    localparam int unsigned AW     = 11;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RD_LAT = 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    logic clk;
    logic reset;
    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External memory: write commits on the strobe edge, read data one edge after r_en1.
    logic [DW-1:0] tb_mem [2**AW];
    always @(posedge clk) begin
        if (bus.mem_w_en)  tb_mem[bus.mem_w_adrs] <= bus.mem_data_in;
        if (bus.mem_r_en1) bus.mem_data_out1 <= tb_mem[bus.mem_r_adrs1];
    end

    int            total = 0;
    int            bad = 0;
    int            wcount = 0;
    int unsigned   acc_cyc = 0;
    bit            rand_ready = 0;
    req_t          q[$];
    logic [DW-1:0] shadow [2**AW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
                if (rand_ready) bus.rsp_ready = ($urandom_range(0, 1) == 1);
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end else chk("send_timeout", 64'd0, 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned n);
        for (int i = 0; i < 200 && !bus.rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
        n = cyc - acc_cyc;
    endtask

    // Waits for a response with rsp_ready high and steps past its handshake edge.
    task automatic take(output logic [DW-1:0] d, output logic [AW-1:0] a);
        int unsigned n;
        wait_valid(n);
        d = bus.rsp_rdata;
        a = bus.rsp_addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            begin : monitor
                bit            hold = 0;
                logic [DW-1:0] hold_d = '0;
                logic [AW-1:0] hold_a = '0;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        q.delete();
                        hold = 0;
                    end else begin
                        if (bus.mem_w_en || bus.mem_r_en1) begin
                            chk("strobe_exclusive", 64'(bus.mem_w_en & bus.mem_r_en1), 64'd0);
                            chk("strobe_in_resp", 64'(bus.rsp_valid), 64'd0);
                        end
                        if (bus.mem_w_en) begin
                            wcount++;
                            if (q.size() == 0) chk("write_unexpected", 64'd1, 64'd0);
                            else begin
                                chk("write_kind", 64'(q[0].we), 64'd1);
                                chk("write_addr", 64'(bus.mem_w_adrs), 64'(q[0].a));
                                chk("write_data", 64'(bus.mem_data_in), 64'(q[0].d));
                                shadow[q[0].a] = q[0].d;
                                void'(q.pop_front());
                            end
                        end
                        if (bus.mem_r_en1) begin
                            if (q.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
                            else begin
                                chk("read_kind", 64'(q[0].we), 64'd0);
                                chk("read_addr", 64'(bus.mem_r_adrs1), 64'(q[0].a));
                            end
                        end
                        if (hold)
                            chk("rsp_held", {31'd0, bus.rsp_valid, bus.rsp_rdata},
                                {31'd0, 1'b1, hold_d});
                        if (hold) chk("rsp_addr_held", 64'(bus.rsp_addr), 64'(hold_a));
                        if (bus.rsp_valid && bus.rsp_ready) begin
                            if (q.size() == 0 || q[0].we) chk("rsp_unexpected", 64'd1, 64'd0);
                            else begin
                                chk("rsp_addr", 64'(bus.rsp_addr), 64'(q[0].a));
                                chk("rsp_data", 64'(bus.rsp_rdata), 64'(shadow[q[0].a]));
                                void'(q.pop_front());
                            end
                        end
                        if (bus.req_valid && bus.req_ready)
                            q.push_back('{we: bus.req_we, a: bus.req_addr, d: bus.req_wdata});
                        hold   = bus.rsp_valid && !bus.rsp_ready;
                        hold_d = bus.rsp_rdata;
                        hold_a = bus.rsp_addr;
                    end
                end
            end
            begin : stim
                int unsigned   n;
                int            w0;
                int unsigned   wr_acc;
                logic [DW-1:0] d0, d1, held;
                logic [AW-1:0] a0, a1, last_a;
                logic [DW-1:0] last_d;
                logic [5:0]    pat;

                reset = 1'b1;
                bus.req_valid = 1'b0;
                bus.req_we    = 1'b0;
                bus.req_addr  = '0;
                bus.req_wdata = '0;
                bus.rsp_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
                chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("reset_strobes", 64'({bus.mem_w_en, bus.mem_r_en1}), 64'd0);
                chk("reset_busy", 64'(bus.busy), 64'd0);
                chk("reset_data", 64'({bus.rsp_rdata, bus.mem_data_in}), 64'd0);
                chk("reset_addr", 64'({bus.rsp_addr, bus.mem_w_adrs, bus.mem_r_adrs1}), 64'd0);
                #2 reset = 1'b0;
                @(posedge clk);
                #1;

                // Write then read the same address on consecutive cycles.
                bus.rsp_ready = 1'b1;
                w0 = wcount;
                send(1'b1, 11'h045, 32'h0000_01A4);
                wr_acc = acc_cyc;
                send(1'b0, 11'h045, '0);
                wait_valid(n);
                chk("raw_latency", 64'(cyc - wr_acc), 64'(RD_LAT + 3));
                chk("raw_data", 64'(bus.rsp_rdata), 64'h1A4);
                chk("raw_addr", 64'(bus.rsp_addr), 64'h045);
                @(posedge clk);
                #1;
                chk("raw_one_write", 64'(wcount - w0), 64'd1);

                // Stall the response and fill the FIFO behind it.
                bus.rsp_ready = 1'b0;
                send(1'b0, 11'h045, '0);
                wait_valid(n);
                held = bus.rsp_rdata;
                chk("stall_data", 64'(held), 64'h1A4);
                for (int i = 0; i < 4; i++) send(1'b1, AW'(11'h200 + i), 32'hA000_0000 + i);
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = 11'h2FF;
                bus.req_wdata = 32'hDEAD_BEEF;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("full_not_ready", 64'(bus.req_ready), 64'd0);
                    chk("stall_stable", 64'(bus.rsp_rdata), 64'(held));
                end
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                bus.rsp_ready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk);
                    #1;
                    pat[k] = bus.mem_w_en;
                end
                chk("drain_pattern", 64'(pat), 64'b011110);

                // Top-of-range addresses and all-ones data.
                send(1'b1, 11'h7FF, 32'hFFFF_FFFF);
                send(1'b1, 11'h7FE, 32'h0000_000F);
                send(1'b0, 11'h7FF, '0);
                send(1'b0, 11'h7FE, '0);
                take(d0, a0);
                take(d1, a1);
                chk("bound_first", {21'd0, a0, d0}, {21'd0, 11'h7FF, 32'hFFFF_FFFF});
                chk("bound_second", {21'd0, a1, d1}, {21'd0, 11'h7FE, 32'h0000_000F});

                // Pointer wrap: three rounds of DEPTH writes, then read the last one back.
                w0 = wcount;
                last_a = '0;
                last_d = '0;
                for (int r = 0; r < 3; r++)
                    for (int j = 0; j < int'(DEPTH); j++) begin
                        last_a = AW'(11'h100 + $urandom_range(0, 15));
                        last_d = $urandom;
                        send(1'b1, last_a, last_d);
                    end
                send(1'b0, last_a, '0);
                take(d0, a0);
                chk("wrap_writes", 64'(wcount - w0), 64'(3 * DEPTH));
                chk("wrap_read", {21'd0, a0, d0}, {21'd0, last_a, last_d});

                // Random mix on a small address set so hazards are frequent.
                for (int i = 0; i < 8; i++) send(1'b1, AW'(i), $urandom);
                rand_ready = 1;
                for (int i = 0; i < 60; i++) begin
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    send(1'(($urandom_range(0, 1))), AW'($urandom_range(0, 7)), $urandom);
                end
                rand_ready = 0;
                bus.rsp_ready = 1'b1;
                for (int i = 0; i < 200 && (bus.busy || q.size() != 0); i++) @(negedge clk);
                chk("drain_queue", 64'(q.size()), 64'd0);
                chk("drain_busy", 64'(bus.busy), 64'd0);

                // Reset while a read waits with two writes queued.
                @(posedge clk);
                #1;
                send(1'b1, 11'h001, 32'hC0FF_EE01);
                repeat (4) @(posedge clk);
                #1;
                send(1'b0, 11'h010, '0);
                send(1'b1, 11'h002, 32'h1111_2222);
                send(1'b1, 11'h001, 32'h3333_4444);
                reset = 1'b1;
                #1;
                chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_strobes", 64'({bus.mem_w_en, bus.mem_r_en1}), 64'd0);
                repeat (2) @(posedge clk);
                #3 reset = 1'b0;
                @(posedge clk);
                #1;
                send(1'b0, 11'h001, '0);
                wait_valid(n);
                chk("post_rst_latency", 64'(n), 64'(RD_LAT + 2));
                chk("post_rst_read", {21'd0, bus.rsp_addr, bus.rsp_rdata},
                    {21'd0, 11'h001, 32'hC0FF_EE01});
                @(posedge clk);
                #1;
                repeat (3) @(posedge clk);
                #1;
                chk("final_busy", 64'(bus.busy), 64'd0);

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_any
    end
endmodule
